// File: rtl/ctrl_fsm.sv
// Multicycle control FSM for the integer datapath: FETCH -> DECODE -> EXEC -> WB per instruction.
// Handles RV32I R-type ALU ops and the M-extension MUL group; anything else traps to HALT.
module ctrl_fsm #(
    parameter int pcmux_N     = 2,
    parameter int ifuresctl_N = 2,
    parameter int MU_TIMEOUT  = 64
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     run,
    input  logic [6:0]                               opcode,
    input  logic [2:0]                               func3,
    input  logic [1:0]                               func7b50,
    input  logic                                     exdone,
    output logic [(pcmux_N > 1 ? $clog2(pcmux_N) : 1)-1:0]         pcmuxctl,
    output logic                                     pcnextctl,
    output logic                                     instrre,
    output logic                                     regre,
    output logic                                     regwe,
    output logic                                     mulstart,
    output logic [3:0]                               aluctl,
    output logic [1:0]                               mulctl,
    output logic [(ifuresctl_N > 1 ? $clog2(ifuresctl_N) : 1)-1:0] ifuresctl,
    output logic                                     halted,
    output logic [1:0]                               err_code,
    output logic [31:0]                              instret
);

    localparam int PW = (pcmux_N > 1) ? $clog2(pcmux_N) : 1;
    localparam int IW = (ifuresctl_N > 1) ? $clog2(ifuresctl_N) : 1;
    localparam int CW = $clog2(MU_TIMEOUT + 1);

    localparam logic [6:0] OP_RTYPE    = 7'b0110011;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_FUNC    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t        state;
    logic          mu_op;
    logic [CW-1:0] cnt;
    logic [1:0]    dec_err;
    logic          dec_mu;

    // The PC always advances by 4 in this core.
    assign pcmuxctl = PW'(0);

    always_comb begin
        dec_err = ERR_NONE;
        dec_mu  = 1'b0;
        if (opcode != OP_RTYPE) begin
            dec_err = ERR_OPCODE;
        end else begin
            case (func7b50)
                2'b00: dec_err = ERR_NONE;
                2'b01: begin
                    if (func3[2]) dec_err = ERR_FUNC;
                    else          dec_mu  = 1'b1;
                end
                2'b10: begin
                    if (!(func3 == 3'b000 || func3 == 3'b101)) dec_err = ERR_FUNC;
                end
                default: dec_err = ERR_FUNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mu_op     <= 1'b0;
            cnt       <= '0;
            pcnextctl <= 1'b0;
            instrre   <= 1'b0;
            regre     <= 1'b0;
            regwe     <= 1'b0;
            mulstart  <= 1'b0;
            aluctl    <= 4'd0;
            mulctl    <= 2'd0;
            ifuresctl <= IW'(0);
            halted    <= 1'b0;
            err_code  <= ERR_NONE;
            instret   <= 32'd0;
        end else begin
            instrre   <= 1'b0;
            regre     <= 1'b0;
            regwe     <= 1'b0;
            pcnextctl <= 1'b0;
            mulstart  <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state   <= FETCH;
                        instrre <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= DECODE;
                    regre <= 1'b1;
                end
                DECODE: begin
                    if (dec_err != ERR_NONE) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        err_code <= dec_err;
                    end else begin
                        state     <= EXEC;
                        aluctl    <= {func7b50[1], func3};
                        mulctl    <= func3[1:0];
                        ifuresctl <= IW'(dec_mu);
                        mu_op     <= dec_mu;
                        mulstart  <= dec_mu;
                        cnt       <= CW'(1);
                    end
                end
                EXEC: begin
                    // exdone in the first MU cycle belongs to a previous op and is ignored.
                    if (!mu_op || (cnt != CW'(1) && exdone)) begin
                        state     <= WB;
                        regwe     <= 1'b1;
                        pcnextctl <= 1'b1;
                    end else if (cnt == CW'(MU_TIMEOUT)) begin
                        state    <= HALT;
                        halted   <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WB: begin
                    instret <= instret + 32'd1;
                    if (run) begin
                        state   <= FETCH;
                        instrre <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        aluctl    <= 4'd0;
                        mulctl    <= 2'd0;
                        ifuresctl <= IW'(0);
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm: one state per tick, outputs checked 1 ns after each rising edge.
module tb_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [1:0]  func7b50;
    logic        exdone;
    logic [0:0]  pcmuxctl;
    logic        pcnextctl;
    logic        instrre;
    logic        regre;
    logic        regwe;
    logic        mulstart;
    logic [3:0]  aluctl;
    logic [1:0]  mulctl;
    logic [0:0]  ifuresctl;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    ctrl_fsm #(.pcmux_N(2), .ifuresctl_N(2), .MU_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func3(func3),
        .func7b50(func7b50), .exdone(exdone), .pcmuxctl(pcmuxctl),
        .pcnextctl(pcnextctl), .instrre(instrre), .regre(regre), .regwe(regwe),
        .mulstart(mulstart), .aluctl(aluctl), .mulctl(mulctl),
        .ifuresctl(ifuresctl), .halted(halted), .err_code(err_code),
        .instret(instret)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins);
        opcode   = ins[6:0];
        func3    = ins[14:12];
        func7b50 = {ins[30], ins[25]};
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        run    = 1'b0;
        exdone = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] all_outs();
        return {pcmuxctl, pcnextctl, instrre, regre, regwe, mulstart,
                aluctl, mulctl, ifuresctl, halted, err_code};
    endfunction

    // scoreboard: expected {instrre, regre, regwe, pcnextctl} per cycle
    task automatic check_en(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {28'd0, instrre, regre, regwe, pcnextctl}, {28'd0, e});
        end
    endtask

    initial begin
        set_instr(32'h0000_0000);
        do_reset();
        check("reset_outs", {16'd0, all_outs()}, 32'd0);
        check("reset_instret", instret, 32'd0);

        // 1: ADD retires in 4 cycles with the enable pattern 1000,0100,0000,0011
        set_instr(32'h0020_81B3);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b0011);
        run = 1'b1;
        tick(); check_en("add_fetch");
        run = 1'b0;
        tick(); check_en("add_decode");
        tick(); check_en("add_exec");
        check("add_aluctl", {28'd0, aluctl}, 32'h0);
        check("add_ifures", {31'd0, ifuresctl}, 32'd0);
        check("add_mulstart", {31'd0, mulstart}, 32'd0);
        tick(); check_en("add_wb");
        check("add_pcmux", {31'd0, pcmuxctl}, 32'd0);
        tick();
        check("add_instret", instret, 32'd1);
        check("add_idle_instrre", {31'd0, instrre}, 32'd0);
        tick();
        check("idle_no_fetch", {31'd0, instrre}, 32'd0);

        // 2: SUB then SRA back to back
        do_reset();
        set_instr(32'h4020_81B3);
        run = 1'b1;
        tick(); tick(); tick();
        check("sub_aluctl", {28'd0, aluctl}, 32'h8);
        tick();
        check("sub_wb_regwe", {31'd0, regwe}, 32'd1);
        set_instr(32'h4020_D1B3);
        tick();
        check("sra_fetch", {31'd0, instrre}, 32'd1);
        tick(); tick();
        check("sra_aluctl", {28'd0, aluctl}, 32'hD);
        run = 1'b0;
        tick(); tick();
        check("subsra_instret", instret, 32'd2);

        // 3: MUL with exdone in the 4th EXEC cycle, then MULHU
        do_reset();
        set_instr(32'h0220_81B3);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick();
        check("mul_start", {31'd0, mulstart}, 32'd1);
        check("mul_mulctl", {30'd0, mulctl}, 32'd0);
        check("mul_ifures", {31'd0, ifuresctl}, 32'd1);
        tick();
        check("mul_start_pulse", {31'd0, mulstart}, 32'd0);
        tick();
        tick();
        check("mul_wait_regwe", {31'd0, regwe}, 32'd0);
        exdone = 1'b1;
        tick();
        exdone = 1'b0;
        check("mul_wb", {30'd0, regwe, pcnextctl}, 32'd3);
        tick();
        check("mul_instret", instret, 32'd1);
        set_instr(32'h0220_B1B3);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick();
        check("mulhu_mulctl", {30'd0, mulctl}, 32'd3);
        exdone = 1'b1;
        tick();
        check("mulhu_stale_ignored", {31'd0, regwe}, 32'd0);
        tick();
        exdone = 1'b0;
        check("mulhu_wb", {31'd0, regwe}, 32'd1);

        // 4: DIV traps with err 2, ADDI traps with err 1; only reset clears
        do_reset();
        set_instr(32'h0220_C1B3);
        run = 1'b1;
        tick(); tick(); tick();
        check("div_halted", {31'd0, halted}, 32'd1);
        check("div_err", {30'd0, err_code}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("div_no_regwe", {30'd0, regwe, instrre}, 32'd0);
            tick();
        end
        check("div_sticky_err", {30'd0, err_code}, 32'd2);
        do_reset();
        check("div_reset_clear", {31'd0, halted}, 32'd0);
        set_instr(32'h0010_8093);
        run = 1'b1;
        tick(); tick(); tick();
        run = 1'b0;
        check("addi_err", {30'd0, err_code}, 32'd1);
        check("addi_halted", {31'd0, halted}, 32'd1);

        // 5: MU timeout at EXEC cycle 8, stale exdone in cycle 1
        do_reset();
        set_instr(32'h0220_81B3);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick();
        exdone = 1'b1;
        tick();
        exdone = 1'b0;
        check("to_stale_ignored", {31'd0, regwe}, 32'd0);
        for (int i = 3; i <= 8; i++) tick();
        check("to_exec8_not_halted", {31'd0, halted}, 32'd0);
        tick();
        check("to_halted", {31'd0, halted}, 32'd1);
        check("to_err", {30'd0, err_code}, 32'd3);
        check("to_no_regwe", {31'd0, regwe}, 32'd0);

        // 6: reset mid MU EXEC clears everything, including instret
        do_reset();
        set_instr(32'h0020_81B3);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick(); tick(); tick();
        check("pre_rst_instret", instret, 32'd1);
        set_instr(32'h0220_81B3);
        run = 1'b1;
        tick();
        tick(); tick(); tick();
        rst_n = 1'b0;
        exdone = 1'b1;
        tick();
        check("midrst_outs", {16'd0, all_outs()}, 32'd0);
        check("midrst_instret", instret, 32'd0);
        rst_n = 1'b1;
        run = 1'b0;
        exdone = 1'b0;
        tick();
        check("midrst_idle", {31'd0, instrre}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // timing invariants checked every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            check("inv_onehot", {31'd0, ($countones({instrre, regre, regwe}) <= 1)}, 32'd1);
            check("inv_regwe_pcnext", {31'd0, regwe}, {31'd0, pcnextctl});
        end
    end

endmodule
